// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered UART transmitter.
// Bytes accepted over the ready_tx/done_tx handshake are queued in a small
// FIFO and serialised LSB-first on tx as start, 8 data bits, optional parity
// and 1 or 2 stop bits. Back-to-back queued bytes go out with no idle gap.
module uart_tx_buf #(
    parameter int CLK_FREQ   = 6_914_890,
    parameter int BAUDRATE   = 38400,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_tx,
    input  logic       ready_tx,
    output logic       done_tx,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full
);

    // Baud timing: every bit state lasts DIV cycles, STOP lasts STOP_BITS*DIV.
    localparam int DIV      = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      wptr_nxt;
    logic [AW:0]      rptr_nxt;
    logic [7:0]       head;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] cnt;
    logic             par_bit;
    logic             empty;
    logic             push;
    logic             pop;

    // Handshake, pop decision and next FIFO pointers.
    always_comb begin
        empty    = (wptr == rptr);
        // done_tx=1 masks a second accept of the byte the producer is still holding.
        push     = ready_tx && !fifo_full && !done_tx;
        pop      = !empty && ((state == S_IDLE) ||
                              ((state == S_STOP) && (cnt == STOP_LAST)));
        wptr_nxt = wptr + {{AW{1'b0}}, push};
        rptr_nxt = rptr + {{AW{1'b0}}, pop};
        head     = mem[rptr[AW-1:0]];
    end

    assign busy = (state != S_IDLE) || !empty;

    // FIFO storage write port.
    // NOTE: the byte array carries no reset; flushing is done by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= data_tx;
        end
    end

    // FIFO pointers, registered full flag and the done_tx pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            fifo_full <= 1'b0;
            done_tx   <= 1'b0;
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            // NOTE: full is registered from the next pointers, so a pop this cycle
            // frees a slot only from the following cycle on.
            fifo_full <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                         (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
            done_tx   <= push;
        end
    end

    // Frame sequencer with registered serial output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= head;
                        par_bit <= (PARITY == 2) ? ^head : ~^head;
                        tx      <= 1'b0;
                        cnt     <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == STOP_LAST) begin
                        cnt <= '0;
                        if (pop) begin
                            shift   <= head;
                            par_bit <= (PARITY == 2) ? ^head : ~^head;
                            tx      <= 1'b0;
                            state   <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed bench for uart_tx_buf with DIV=16, FIFO_DEPTH=4.
// Three instances share clk/rst: a = no parity/1 stop, b = even/2 stop,
// c = odd/1 stop. Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_buf;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_a = 8'h00, data_b = 8'h00, data_c = 8'h00;
    logic       ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;
    logic       done_a, done_b, done_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic       full_a, full_b, full_c;

    int errors = 0;
    int checks = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    uart_tx_buf #(.CLK_FREQ(16), .BAUDRATE(1), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .data_tx(data_a), .ready_tx(ready_a),
        .done_tx(done_a), .tx(tx_a), .busy(busy_a), .fifo_full(full_a));

    uart_tx_buf #(.CLK_FREQ(16), .BAUDRATE(1), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .data_tx(data_b), .ready_tx(ready_b),
        .done_tx(done_b), .tx(tx_b), .busy(busy_b), .fifo_full(full_b));

    uart_tx_buf #(.CLK_FREQ(16), .BAUDRATE(1), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .data_tx(data_c), .ready_tx(ready_c),
        .done_tx(done_c), .tx(tx_c), .busy(busy_c), .fifo_full(full_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int k);
        case (k)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic done_of(input int k);
        case (k)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic drive(input int k, input logic rdy, input logic [7:0] d);
        case (k)
            0:       begin ready_a = rdy; data_a = d; end
            1:       begin ready_b = rdy; data_b = d; end
            default: begin ready_c = rdy; data_c = d; end
        endcase
    endtask

    // Offer a byte and hold ready until done_tx is seen; returns on that falling edge.
    task automatic send(input int k, input logic [7:0] b, input bit release_rdy, input string tag);
        bit got = 1'b0;
        drive(k, 1'b1, b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_of(k)) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " accepted"}, 32'(got), 32'd1);
        if (release_rdy) drive(k, 1'b0, 8'h00);
    endtask

    // Walk one frame from the current falling edge (skip = start cycles already
    // elapsed). One comparison per slot counting cycles at the expected level,
    // plus the byte decoded at mid-bit. Ends on the last stop-bit cycle.
    task automatic check_frame(input int k, input logic [7:0] b, input bit has_par,
                               input logic pbit, input int stops, input int skip,
                               input string tag);
        int   nslot = has_par ? 11 : 10;
        bit   first = 1'b1;
        logic [7:0] dec = 8'h00;
        busy_cnt = 0;
        for (int s = 0; s < nslot; s++) begin
            int   len   = (s == nslot - 1) ? DIV * stops : DIV;
            int   hits  = 0;
            int   want  = (s == 0) ? len - skip : len;
            logic lvl;
            if (s == 0)                     lvl = 1'b0;
            else if (s <= 8)                lvl = b[s-1];
            else if (has_par && s == 9)     lvl = pbit;
            else                            lvl = 1'b1;
            for (int c = 0; c < len; c++) begin
                if (s == 0 && c < skip) continue;
                if (!first) @(negedge clk);
                first = 1'b0;
                if (tx_of(k) === lvl) hits++;
                if (busy_of(k) === 1'b1) busy_cnt++;
                if (s >= 1 && s <= 8 && c == DIV / 2) dec[s-1] = tx_of(k);
            end
            check($sformatf("%s slot%0d", tag, s), 32'(hits), 32'(want));
        end
        check({tag, " decoded"}, 32'(dec), 32'(b));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        bit   ok;
        logic prev_full;

        // 1: reset held for 3 cycles, outputs quiet throughout and after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d outs", i), {28'd0, tx_a, done_a, busy_a, full_a}, 32'b1000);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post-rst outs a", {28'd0, tx_a, done_a, busy_a, full_a}, 32'b1000);
        check("post-rst outs b", {28'd0, tx_b, done_b, busy_b, full_b}, 32'b1000);

        // 2: single byte 0x55, no parity, 1 stop.
        send(0, 8'h55, 1'b1, "t2");
        check("t2 tx before start", 32'(tx_a), 32'd1);
        @(negedge clk);
        check("t2 done single pulse", 32'(done_a), 32'd0);
        check("t2 tx falls accept+1", 32'(tx_a), 32'd0);
        check_frame(0, 8'h55, 1'b0, 1'b0, 1, 0, "t2");
        check("t2 busy cycles", 32'(busy_cnt), 32'd160);
        @(negedge clk);
        check("t2 idle after frame", {30'd0, tx_a, busy_a}, 32'b10);

        // 3: two bytes back to back, no idle gap between frames.
        send(0, 8'hA5, 1'b0, "t3a");
        send(0, 8'h3C, 1'b1, "t3b");
        check_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1, "t3 f1");
        @(negedge clk);
        check("t3 no gap", 32'(tx_a), 32'd0);
        check_frame(0, 8'h3C, 1'b0, 1'b0, 1, 0, "t3 f2");
        @(negedge clk);
        check("t3 idle", {30'd0, tx_a, busy_a}, 32'b10);

        // 4: six bytes offered continuously into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send(0, 8'(i * 8'h11), 1'b0, $sformatf("t4 b%0d", i));
        end
        check("t4 full after 5", 32'(full_a), 32'd1);
        drive(0, 1'b1, 8'h66);
        n = 0;
        ok = 1'b0;
        prev_full = full_a;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done_a) begin
                n = i;
                ok = 1'b1;
                break;
            end
            prev_full = full_a;
        end
        drive(0, 1'b0, 8'h00);
        check("t4 b6 accepted", 32'(ok), 32'd1);
        check("t4 b6 wait cycles", 32'(n), 32'd154);
        check("t4 full dropped first", 32'(prev_full), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4 drained", 32'(ok), 32'd1);
        check("t4 not full", 32'(full_a), 32'd0);

        // 5: parity and stop-bit variants on 0x07 (three ones).
        send(1, 8'h07, 1'b1, "t5 even");
        @(negedge clk);
        check("t5 even start", 32'(tx_b), 32'd0);
        check_frame(1, 8'h07, 1'b1, 1'b1, 2, 0, "t5 even");
        check("t5 even frame cycles", 32'(busy_cnt), 32'd192);
        @(negedge clk);
        check("t5 even idle", {30'd0, tx_b, busy_b}, 32'b10);

        send(2, 8'h07, 1'b1, "t5 odd");
        @(negedge clk);
        check("t5 odd start", 32'(tx_c), 32'd0);
        check_frame(2, 8'h07, 1'b1, 1'b0, 1, 0, "t5 odd");
        check("t5 odd frame cycles", 32'(busy_cnt), 32'd176);

        // 6: three bytes queued, reset during data bit 3 of the first frame.
        send(0, 8'h81, 1'b0, "t6 b1");
        send(0, 8'h42, 1'b0, "t6 b2");
        send(0, 8'h24, 1'b1, "t6 b3");
        repeat (65) @(negedge clk);
        check("t6 in data bit3", 32'(tx_a), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 after rst outs", {28'd0, tx_a, done_a, busy_a, full_a}, 32'b1000);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) n++;
        end
        check("t6 quiet cycles bad", 32'(n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
